// File: rtl/gshare_bht_pkg.sv
// Shared types, constants and history helper for the gshare branch history table.
package gshare_bht_pkg;

    localparam int VLEN_DEF       = 32;
    localparam int NR_ENTRIES_DEF = 1024;
    localparam int GHR_BITS_DEF   = 10;
    localparam int PC_OFFSET_DEF  = 1;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_WEAK_NT = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bht_state_e;

    // Works on a 32-bit container; callers truncate to their own history width.
    function automatic logic [31:0] ghr_shift(input logic [31:0] ghr, input logic bit_in);
        return {ghr[30:0], bit_in};
    endfunction

endpackage

// File: rtl/gshare_bht_if.sv
// Frontend / resolve-side bus of the gshare BHT; the predictor itself uses the slave side.
interface gshare_bht_if #(
    parameter int VLEN     = 32,
    parameter int GHR_BITS = 10
);
    logic                flush_bp_i;
    logic                lookup_valid_i;
    logic [VLEN-1:0]     lookup_pc_i;
    logic                pred_valid_o;
    logic                pred_taken_o;
    logic [GHR_BITS-1:0] pred_ghr_o;
    logic                spec_valid_i;
    logic                spec_taken_i;
    logic                upd_valid_i;
    logic [VLEN-1:0]     upd_pc_i;
    logic [GHR_BITS-1:0] upd_ghr_i;
    logic                upd_taken_i;
    logic                upd_mispredict_i;
    logic                busy_o;
    logic [31:0]         perf_lookups_o;
    logic [31:0]         perf_mispredicts_o;

    modport master (
        output flush_bp_i, lookup_valid_i, lookup_pc_i, spec_valid_i, spec_taken_i,
               upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
        input  pred_valid_o, pred_taken_o, pred_ghr_o, busy_o,
               perf_lookups_o, perf_mispredicts_o
    );

    modport slave (
        input  flush_bp_i, lookup_valid_i, lookup_pc_i, spec_valid_i, spec_taken_i,
               upd_valid_i, upd_pc_i, upd_ghr_i, upd_taken_i, upd_mispredict_i,
        output pred_valid_o, pred_taken_o, pred_ghr_o, busy_o,
               perf_lookups_o, perf_mispredicts_o
    );
endinterface

// File: rtl/gshare_sat_ctr.sv
// Combinational 2-bit saturating counter step: up on taken, down on not-taken.
module gshare_sat_ctr
    import gshare_bht_pkg::*;
(
    input  bht_ctr_t cur_i,
    input  logic     taken_i,
    output bht_ctr_t nxt_o
);
    always_comb begin
        nxt_o = cur_i;
        if (taken_i) begin
            if (cur_i != 2'b11) nxt_o = cur_i + 2'b01;
        end else begin
            if (cur_i != 2'b00) nxt_o = cur_i - 2'b01;
        end
    end
endmodule

// File: rtl/gshare_bht.sv
// Gshare branch history table: PC xor GHR indexed 2-bit counters, registered prediction,
// speculative GHR with mispredict repair, flush sweep. Optional perf counters: GSHARE_BHT_PERF_EN.
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter int VLEN       = VLEN_DEF,
    parameter int NR_ENTRIES = NR_ENTRIES_DEF,
    parameter int GHR_BITS   = GHR_BITS_DEF,
    parameter int PC_OFFSET  = PC_OFFSET_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    gshare_bht_if.slave bht
);
    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    bht_state_e          state_q, state_d;
    logic [IDX_W-1:0]    sweep_idx_q, sweep_idx_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    bht_ctr_t            ctr_q [NR_ENTRIES];

    logic                pred_valid_q, pred_taken_q;
    logic [GHR_BITS-1:0] pred_ghr_q;

    logic [IDX_W-1:0]    lookup_idx, upd_idx;
    logic                is_idle, lookup_acc, upd_we, misp_we;
    bht_ctr_t            upd_cur, upd_nxt;
    logic                unused_pc;

    assign lookup_idx = bht.lookup_pc_i[IDX_W+PC_OFFSET-1:PC_OFFSET] ^ IDX_W'(ghr_q);
    assign upd_idx    = bht.upd_pc_i[IDX_W+PC_OFFSET-1:PC_OFFSET] ^ IDX_W'(bht.upd_ghr_i);

    assign is_idle    = (state_q == IDLE);
    assign lookup_acc = is_idle & bht.lookup_valid_i;
    assign upd_we     = is_idle & bht.upd_valid_i;
    assign misp_we    = upd_we & bht.upd_mispredict_i;

    assign unused_pc = ^{bht.lookup_pc_i[VLEN-1:IDX_W+PC_OFFSET], bht.lookup_pc_i[PC_OFFSET-1:0],
                         bht.upd_pc_i[VLEN-1:IDX_W+PC_OFFSET], bht.upd_pc_i[PC_OFFSET-1:0]};

    assign upd_cur = ctr_q[upd_idx];

    gshare_sat_ctr u_sat_ctr (
        .cur_i   (upd_cur),
        .taken_i (bht.upd_taken_i),
        .nxt_o   (upd_nxt)
    );

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        ghr_d       = ghr_q;
        case (state_q)
            IDLE: begin
                if (bht.flush_bp_i) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                    ghr_d       = '0;
                end else if (misp_we) begin
                    // Repair from the branch's own snapshot, not the live (wrong-path) history.
                    ghr_d = GHR_BITS'(ghr_shift(32'(bht.upd_ghr_i), bht.upd_taken_i));
                end else if (bht.spec_valid_i) begin
                    ghr_d = GHR_BITS'(ghr_shift(32'(ghr_q), bht.spec_taken_i));
                end
            end
            SWEEP: begin
                if (bht.flush_bp_i) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == LAST_IDX) begin
                    state_d     = IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sweep_idx_q <= '0;
            ghr_q       <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            ghr_q       <= ghr_d;
        end
    end

    // Counters need an asynchronous bulk reset, so they live in flops rather than RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) ctr_q[i] <= CTR_WEAK_NT;
        end else if (state_q == SWEEP) begin
            ctr_q[sweep_idx_q] <= CTR_WEAK_NT;
        end else if (upd_we) begin
            ctr_q[upd_idx] <= upd_nxt;
        end
    end

    // Lookup samples pre-edge contents, so a same-cycle update is not visible yet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            pred_valid_q <= lookup_acc;
            if (lookup_acc) begin
                pred_taken_q <= ctr_q[lookup_idx][1];
                pred_ghr_q   <= ghr_q;
            end
        end
    end

    assign bht.pred_valid_o = pred_valid_q;
    assign bht.pred_taken_o = pred_taken_q;
    assign bht.pred_ghr_o   = pred_ghr_q;
    assign bht.busy_o       = (state_q == SWEEP);

`ifdef GSHARE_BHT_PERF_EN
    logic [31:0] perf_lookups_q, perf_misp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_lookups_q <= '0;
            perf_misp_q    <= '0;
        end else begin
            if (lookup_acc) perf_lookups_q <= perf_lookups_q + 32'd1;
            if (misp_we)    perf_misp_q    <= perf_misp_q + 32'd1;
        end
    end

    assign bht.perf_lookups_o     = perf_lookups_q;
    assign bht.perf_mispredicts_o = perf_misp_q;
`else
    assign bht.perf_lookups_o     = 32'd0;
    assign bht.perf_mispredicts_o = 32'd0;
`endif

endmodule

// File: tb/tb_gshare_bht.sv
// Directed self-checking bench for gshare_bht; build with GSHARE_BHT_PERF_EN to check perf counters.
module tb_gshare_bht;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    gshare_bht_if #(.VLEN(32), .GHR_BITS(10)) bus ();

    gshare_bht dut (
        .clk_i (clk),
        .rst_i (rst),
        .bht   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-20s got=0x%0h exp=0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-20s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_bp_i       = 1'b0;
        bus.lookup_valid_i   = 1'b0;
        bus.lookup_pc_i      = '0;
        bus.spec_valid_i     = 1'b0;
        bus.spec_taken_i     = 1'b0;
        bus.upd_valid_i      = 1'b0;
        bus.upd_pc_i         = '0;
        bus.upd_ghr_i        = '0;
        bus.upd_taken_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = pc;
        step();
        bus.lookup_valid_i = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [9:0] ghr,
                          input logic taken, input logic misp);
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = pc;
        bus.upd_ghr_i        = ghr;
        bus.upd_taken_i      = taken;
        bus.upd_mispredict_i = misp;
        step();
        bus.upd_valid_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
    endtask

    task automatic spec(input logic b);
        bus.spec_valid_i = 1'b1;
        bus.spec_taken_i = b;
        step();
        bus.spec_valid_i = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        idle_inputs();
        step();
        step();
        check_eq("rst_pred_valid", bus.pred_valid_o, 0);
        check_eq("rst_pred_taken", bus.pred_taken_o, 0);
        check_eq("rst_pred_ghr",   bus.pred_ghr_o, 0);
        check_eq("rst_busy",       bus.busy_o, 0);
        check_eq("rst_perf_lk",    bus.perf_lookups_o, 0);
        rst = 1'b0;
        step();

        // Fresh table: weakly not-taken, GHR 0
        lookup(32'h8000_0000);
        check_eq("first_valid", bus.pred_valid_o, 1);
        check_eq("first_taken", bus.pred_taken_o, 0);
        check_eq("first_ghr",   bus.pred_ghr_o, 0);
        step();
        check_eq("valid_drops", bus.pred_valid_o, 0);

        // Index 0x80 trained up, saturation, then back down
        for (int i = 0; i < 3; i++) update(32'h100, 10'h0, 1'b1, 1'b0);
        lookup(32'h100);
        check_eq("train3_taken", bus.pred_taken_o, 1);
        update(32'h100, 10'h0, 1'b1, 1'b0);
        update(32'h100, 10'h0, 1'b0, 1'b0);
        lookup(32'h100);
        check_eq("sat_then_dec", bus.pred_taken_o, 1);
        update(32'h100, 10'h0, 1'b0, 1'b0);
        lookup(32'h100);
        check_eq("dec_to_01", bus.pred_taken_o, 0);

        // Speculative history and xor indexing
        spec(1'b1);
        spec(1'b0);
        spec(1'b1);
        update(32'h0, 10'h005, 1'b1, 1'b0);
        lookup(32'h0);
        check_eq("spec_ghr_101", bus.pred_ghr_o, 10'h005);
        check_eq("xor_idx_taken", bus.pred_taken_o, 1);
        lookup(32'hA);
        check_eq("xor_idx_other", bus.pred_taken_o, 0);

        // Mispredict repair wins over a same-cycle spec shift
        bus.spec_valid_i = 1'b1;
        bus.spec_taken_i = 1'b1;
        update(32'h0, 10'h3FF, 1'b0, 1'b1);
        bus.spec_valid_i = 1'b0;
        lookup(32'h0);
        check_eq("misp_ghr_3fe", bus.pred_ghr_o, 10'h3FE);
        update(32'h200, 10'h000, 1'b0, 1'b1);

        // Collision: lookup sees old counter, write lands at the edge
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = 32'h40;
        update(32'h40, 10'h0, 1'b1, 1'b0);
        bus.lookup_valid_i = 1'b0;
        check_eq("coll_old_value", bus.pred_taken_o, 0);
        check_eq("coll_ghr_zero",  bus.pred_ghr_o, 0);
        lookup(32'h40);
        check_eq("coll_new_value", bus.pred_taken_o, 1);

        // Index 5 to 11, dirty GHR, then flush sweep
        update(32'hA, 10'h0, 1'b1, 1'b0);
        lookup(32'hA);
        check_eq("idx5_trained", bus.pred_taken_o, 1);
        spec(1'b1);
        bus.flush_bp_i = 1'b1;
        step();
        bus.flush_bp_i = 1'b0;
        check_eq("flush_busy", bus.busy_o, 1);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = 32'hA;
        cnt = 0;
        bad = 0;
        while (bus.busy_o && cnt < 3000) begin
            step();
            cnt++;
            if (bus.pred_valid_o) bad++;
        end
        idle_inputs();
        check_eq("sweep_len", cnt, 1024);
        check_eq("sweep_no_pred", bad, 0);
        lookup(32'hA);
        check_eq("post_flush_taken", bus.pred_taken_o, 0);
        check_eq("post_flush_ghr",   bus.pred_ghr_o, 0);

        // Restart at busy cycle 500; updates and spec shifts are ignored meanwhile
        bus.flush_bp_i = 1'b1;
        step();
        bus.flush_bp_i = 1'b0;
        bus.spec_valid_i = 1'b1;
        bus.spec_taken_i = 1'b1;
        bus.upd_valid_i  = 1'b1;
        bus.upd_pc_i     = 32'hA;
        bus.upd_taken_i  = 1'b1;
        cnt = 0;
        while (bus.busy_o && cnt < 3000) begin
            bus.flush_bp_i = (cnt == 499);
            step();
            cnt++;
        end
        idle_inputs();
        check_eq("restart_len", cnt, 1524);
        lookup(32'hA);
        check_eq("sweep_ign_upd",  bus.pred_taken_o, 0);
        check_eq("sweep_ign_spec", bus.pred_ghr_o, 0);

        // Asynchronous reset mid-sweep
        update(32'hE, 10'h0, 1'b1, 1'b0);
        update(32'hE, 10'h0, 1'b1, 1'b0);
        lookup(32'hE);
        check_eq("idx7_trained", bus.pred_taken_o, 1);
        bus.flush_bp_i = 1'b1;
        step();
        bus.flush_bp_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("async_rst_busy", bus.busy_o, 0);
        step();
        rst = 1'b0;
        lookup(32'hE);
        check_eq("rst_idx7_weak", bus.pred_taken_o, 0);

        // Perf counters from a clean reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) lookup(32'h1000 + 32'(i * 4));
        for (int i = 0; i < 3; i++) update(32'h2000, 10'h0, 1'b0, 1'b1);
        step();
`ifdef GSHARE_BHT_PERF_EN
        check_eq("perf_lookups", bus.perf_lookups_o, 10);
        check_eq("perf_misp",    bus.perf_mispredicts_o, 3);
`else
        check_eq("perf_lookups", bus.perf_lookups_o, 0);
        check_eq("perf_misp",    bus.perf_mispredicts_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gshare_bht.md
Name: gshare_bht

Overview:
- Gshare branch history table for the cv32a65x frontend. It is selected when BranchPredictorImpl = 1 and sized from BHTEntries = 1024.
- It sits beside the instruction fetch stage. It consumes fetch PCs and gives the frontend a registered taken/not-taken prediction.
- It is trained by resolved branches from the execute/commit side.
- It keeps a speculative global history register (GHR). The GHR is repaired on mispredict.

Parameters:
- VLEN, 32, virtual PC width.
- NR_ENTRIES, 1024, number of 2-bit counters; power of two, ≥ 2.
- GHR_BITS, 10, global history length; must be ≤ log2(NR_ENTRIES).
- PC_OFFSET, 1, low PC bits dropped before indexing (RVC halfword alignment).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_bp_i  in  1  start a table re-initialisation sweep.
- lookup_valid_i  in  1  fetch lookup request.
- lookup_pc_i  in  VLEN  fetch PC.
- pred_valid_o  out  1  prediction valid, one cycle after the lookup.
- pred_taken_o  out  1  predicted direction (counter MSB).
- pred_ghr_o  out  GHR_BITS  GHR value used to form the prediction index; the frontend carries it with the branch.
- spec_valid_i  in  1  frontend commits a speculative history shift.
- spec_taken_i  in  1  bit shifted into the GHR.
- upd_valid_i  in  1  resolved conditional branch.
- upd_pc_i  in  VLEN  branch PC.
- upd_ghr_i  in  GHR_BITS  history snapshot carried with the branch.
- upd_taken_i  in  1  actual outcome.
- upd_mispredict_i  in  1  direction was mispredicted.
- busy_o  out  1  flush sweep in progress.
- perf_lookups_o  out  32  lookup count (optional feature).
- perf_mispredicts_o  out  32  mispredict count (optional feature).

Behaviour:
- Index rule:
  - IDX_W = log2(NR_ENTRIES).
  - idx = pc[IDX_W+PC_OFFSET-1 : PC_OFFSET] XOR zero-extended GHR.
  - Lookups use the live GHR. Updates use upd_ghr_i.
- Reset (rst_i high, asynchronous):
  - Every counter = 2'b01 (weakly not-taken); GHR = 0; FSM = IDLE.
  - pred_valid_o = 0, pred_taken_o = 0, pred_ghr_o = 0, busy_o = 0, perf counters = 0.
  - Reset asserted mid-sweep aborts the sweep; the table still ends at all 2'b01.
- Lookup:
  - Latency 1. In cycle N with lookup_valid_i = 1 in IDLE, cycle N+1 shows:
    - pred_valid_o = 1;
    - pred_taken_o = MSB of counter[idx];
    - pred_ghr_o = GHR value in cycle N.
  - No back-pressure; a new lookup is accepted every cycle.
- Counter update (upd_valid_i in IDLE):
  - Counter at the update index moves +1 if taken, −1 if not taken.
  - Saturates at 2'b11 and 2'b00.
- Read/write collision: a lookup and an update to the same index in the same cycle → the lookup returns the old value. The write lands at the clock edge.
- GHR update priority, highest first:
  1. upd_valid_i & upd_mispredict_i → GHR = {upd_ghr_i[GHR_BITS-2:0], upd_taken_i}.
  2. spec_valid_i → GHR = {GHR[GHR_BITS-2:0], spec_taken_i}.
  3. Otherwise hold.
- FSM IDLE:
  - flush_bp_i → SWEEP; sweep_idx = 0; GHR = 0.
- FSM SWEEP:
  - Each cycle writes counter[sweep_idx] = 2'b01, then sweep_idx+1.
  - After writing index NR_ENTRIES−1 → IDLE. The sweep takes exactly NR_ENTRIES cycles.
  - busy_o = 1. Lookups produce pred_valid_o = 0. Updates and spec shifts are ignored.
  - flush_bp_i during SWEEP restarts at index 0.
- sweep_idx is IDX_W bits wide; the terminal condition is compared before it wraps.

Optional Feature:
- Macro: GSHARE_BHT_PERF_EN.
- Defined:
  - perf_lookups_o increments on each accepted lookup (IDLE & lookup_valid_i).
  - perf_mispredicts_o increments on each upd_valid_i & upd_mispredict_i in IDLE.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by reset only (not by flush).
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package gshare_bht_pkg holds:
  - bht_ctr_t (logic [1:0]);
  - CTR_WEAK_NT = 2'b01;
  - enum bht_state_e {IDLE, SWEEP};
  - function ghr_shift(ghr, bit).
- One sub-module, gshare_sat_ctr: combinational 2-bit saturating next-value (inputs cur, taken; output nxt). It is instantiated once on the update path.

Test Plan:
- Reset, then lookup pc=0x8000_0000 → next cycle pred_valid_o=1, pred_taken_o=0, pred_ghr_o=0.
- Three updates pc=0x100, ghr=0, taken=1, then lookup pc=0x100 with GHR=0 → pred_taken_o=1. Counter saturates at 2'b11; a 4th taken update leaves it at 11, and one not-taken update brings it to 10 (still taken).
- Spec shifts 1,0,1 → pred_ghr_o=0b101. Then a mispredict update with upd_ghr_i=0x3FF and taken=0 in the same cycle as spec_valid_i=1 → GHR=0x3FE (mispredict wins).
- Update and lookup to the same index in the same cycle with counter=01, taken=1 → the lookup returns taken=0; the next lookup returns taken=1.
- Train index 5 to 11, then pulse flush_bp_i → busy_o high for exactly 1024 cycles and pred_valid_o=0 throughout. Afterwards index 5 predicts not-taken and GHR=0. A second flush_bp_i at sweep cycle 500 extends busy_o to 500+1024 cycles.
- With GSHARE_BHT_PERF_EN: 10 lookups and 3 mispredicts → perf_lookups_o=10, perf_mispredicts_o=3. Without the macro both read 0.
